// File: rtl/alu_pkg.sv
// Shared constants for the execute-stage ALU datapath.
package alu_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned REGW = 5;

    // ALU function select, taken directly from instruction bits 14:12
    typedef enum logic [2:0] {
        F3_ADD  = 3'b000,
        F3_SLL  = 3'b001,
        F3_SLT  = 3'b010,
        F3_SLTU = 3'b011,
        F3_XOR  = 3'b100,
        F3_SR   = 3'b101,
        F3_OR   = 3'b110,
        F3_AND  = 3'b111
    } funct3_e;

endpackage

// File: rtl/fwd_mux.sv
// Per-source operand forwarding: MEM beats WB beats register file; x0 reads 0.
module fwd_mux #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned REGW = 5
) (
    input  logic [REGW-1:0] idx,
    input  logic [XLEN-1:0] rf_val,
    input  logic            mem_valid,
    input  logic [REGW-1:0] mem_rd,
    input  logic [XLEN-1:0] mem_data,
    input  logic            wb_valid,
    input  logic [REGW-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] val
);

    logic mem_hit;
    logic wb_hit;

    // Priority select of the freshest producer for this source index
    always_comb begin
        mem_hit = mem_valid && (mem_rd == idx);
        wb_hit  = wb_valid && (wb_rd == idx);
        val     = rf_val;
        if (idx == '0) begin
            val = '0;
        end else if (mem_hit) begin
            val = mem_data;
        end else if (wb_hit) begin
            val = wb_data;
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Execute-stage operand register feeding the ALU: forwarding, operand
// select, precomputed compares and a valid/ready output register.
module alu_operand_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [alu_pkg::REGW-1:0] in_rs1,
    input  logic [alu_pkg::REGW-1:0] in_rs2,
    input  logic [alu_pkg::REGW-1:0] in_rd,
    input  logic [XLEN-1:0]          in_rs1_val,
    input  logic [XLEN-1:0]          in_rs2_val,
    input  logic [XLEN-1:0]          in_imm,
    input  logic                     in_use_imm,
    input  logic [2:0]               in_funct3,
    input  logic                     in_b30,
    input  logic                     fwd_mem_valid,
    input  logic                     fwd_wb_valid,
    input  logic [alu_pkg::REGW-1:0] fwd_mem_rd,
    input  logic [alu_pkg::REGW-1:0] fwd_wb_rd,
    input  logic [XLEN-1:0]          fwd_mem_data,
    input  logic [XLEN-1:0]          fwd_wb_data,
    input  logic                     flush,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [XLEN-1:0]          alu_a,
    output logic [XLEN-1:0]          alu_b,
    output logic [2:0]               alu_operation,
    output logic                     alu_control,
    output logic                     alu_lt,
    output logic                     alu_ltu,
    output logic [alu_pkg::REGW-1:0] out_rd
);

    import alu_pkg::*;

    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            nxt_control;
    logic            nxt_lt;
    logic            nxt_ltu;
    logic            capture;

    fwd_mux #(
        .XLEN (XLEN),
        .REGW (REGW)
    ) u_fwd_rs1 (
        .idx       (in_rs1),
        .rf_val    (in_rs1_val),
        .mem_valid (fwd_mem_valid),
        .mem_rd    (fwd_mem_rd),
        .mem_data  (fwd_mem_data),
        .wb_valid  (fwd_wb_valid),
        .wb_rd     (fwd_wb_rd),
        .wb_data   (fwd_wb_data),
        .val       (rs1_fwd)
    );

    fwd_mux #(
        .XLEN (XLEN),
        .REGW (REGW)
    ) u_fwd_rs2 (
        .idx       (in_rs2),
        .rf_val    (in_rs2_val),
        .mem_valid (fwd_mem_valid),
        .mem_rd    (fwd_mem_rd),
        .mem_data  (fwd_mem_data),
        .wb_valid  (fwd_wb_valid),
        .wb_rd     (fwd_wb_rd),
        .wb_data   (fwd_wb_data),
        .val       (rs2_fwd)
    );

    // Handshake: a held instruction blocks decode until the consumer takes it
    always_comb begin
        in_ready = !out_valid || out_ready;
        capture  = in_valid && in_ready;
    end

    // Operand select, compares and sub/sra control for the incoming instruction
    always_comb begin
        op_a    = rs1_fwd;
        op_b    = in_use_imm ? in_imm : rs2_fwd;
        nxt_lt  = $signed(op_a) < $signed(op_b);
        nxt_ltu = op_a < op_b;
        // I-type only has an alternate form for shift-right (srai); addi etc. never subtract
        nxt_control = in_b30;
        if (in_use_imm && (in_funct3 != F3_SR)) begin
            nxt_control = 1'b0;
        end
    end

    // Output pipeline register; flush kills validity but data may still load
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid     <= 1'b0;
            alu_a         <= '0;
            alu_b         <= '0;
            alu_operation <= '0;
            alu_control   <= 1'b0;
            alu_lt        <= 1'b0;
            alu_ltu       <= 1'b0;
            out_rd        <= '0;
        end else begin
            if (capture) begin
                alu_a         <= op_a;
                alu_b         <= op_b;
                alu_operation <= in_funct3;
                alu_control   <= nxt_control;
                alu_lt        <= nxt_lt;
                alu_ltu       <= nxt_ltu;
                out_rd        <= in_rd;
            end
            if (flush) begin
                out_valid <= 1'b0;
            end else if (capture) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed plus randomized check of alu_operand_stage against a scoreboard.
module tb_alu_operand_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic [31:0] in_rs1_val, in_rs2_val, in_imm;
    logic        in_use_imm;
    logic [2:0]  in_funct3;
    logic        in_b30;
    logic        fwd_mem_valid, fwd_wb_valid;
    logic [4:0]  fwd_mem_rd, fwd_wb_rd;
    logic [31:0] fwd_mem_data, fwd_wb_data;
    logic        flush;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] alu_a, alu_b;
    logic [2:0]  alu_operation;
    logic        alu_control, alu_lt, alu_ltu;
    logic [4:0]  out_rd;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic        ctl;
        logic        lt;
        logic        ltu;
        logic [4:0]  rd;
    } exp_t;

    exp_t q[$];
    logic m_valid;
    int   n_cmp;
    int   n_err;

    alu_operand_stage #(.XLEN(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rs1        (in_rs1),
        .in_rs2        (in_rs2),
        .in_rd         (in_rd),
        .in_rs1_val    (in_rs1_val),
        .in_rs2_val    (in_rs2_val),
        .in_imm        (in_imm),
        .in_use_imm    (in_use_imm),
        .in_funct3     (in_funct3),
        .in_b30        (in_b30),
        .fwd_mem_valid (fwd_mem_valid),
        .fwd_wb_valid  (fwd_wb_valid),
        .fwd_mem_rd    (fwd_mem_rd),
        .fwd_wb_rd     (fwd_wb_rd),
        .fwd_mem_data  (fwd_mem_data),
        .fwd_wb_data   (fwd_wb_data),
        .flush         (flush),
        .out_ready     (out_ready),
        .out_valid     (out_valid),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_operation (alu_operation),
        .alu_control   (alu_control),
        .alu_lt        (alu_lt),
        .alu_ltu       (alu_ltu),
        .out_rd        (out_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_fwd(input logic [4:0] idx, input logic [31:0] rf);
        if (idx == 5'd0) return 32'd0;
        if (fwd_mem_valid && fwd_mem_rd == idx) return fwd_mem_data;
        if (fwd_wb_valid && fwd_wb_rd == idx) return fwd_wb_data;
        return rf;
    endfunction

    function automatic exp_t ref_model();
        exp_t e;
        e.a   = ref_fwd(in_rs1, in_rs1_val);
        e.b   = in_use_imm ? in_imm : ref_fwd(in_rs2, in_rs2_val);
        e.op  = in_funct3;
        e.ctl = in_use_imm ? ((in_funct3 == 3'b101) ? in_b30 : 1'b0) : in_b30;
        e.lt  = $signed(e.a) < $signed(e.b);
        e.ltu = e.a < e.b;
        e.rd  = in_rd;
        return e;
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_a"}, alu_a, 0);
        chk({tag, "_b"}, alu_b, 0);
        chk({tag, "_op"}, alu_operation, 0);
        chk({tag, "_ctl"}, alu_control, 0);
        chk({tag, "_lt"}, alu_lt, 0);
        chk({tag, "_ltu"}, alu_ltu, 0);
        chk({tag, "_rd"}, out_rd, 0);
    endtask

    // One clock: check in_ready, update the scoreboard, then check registered outputs
    task automatic step();
        logic exp_rdy;
        logic cap;
        #2;
        exp_rdy = !m_valid || out_ready;
        chk("in_ready", in_ready, exp_rdy);
        cap = in_valid && exp_rdy;
        if (rst) begin
            q.delete();
            m_valid = 1'b0;
        end else begin
            if (m_valid && (out_ready || flush)) void'(q.pop_front());
            if (cap && !flush) q.push_back(ref_model());
            m_valid = flush ? 1'b0 : cap ? 1'b1 : out_ready ? 1'b0 : m_valid;
        end
        @(posedge clk);
        #1;
        chk("out_valid", out_valid, m_valid);
        if (rst) begin
            check_zero("rst");
        end else if (m_valid) begin
            if (q.size() == 0) begin
                chk("sb_empty", 32'd0, 32'd1);
            end else begin
                chk("alu_a", alu_a, q[0].a);
                chk("alu_b", alu_b, q[0].b);
                chk("alu_op", alu_operation, q[0].op);
                chk("alu_ctl", alu_control, q[0].ctl);
                chk("alu_lt", alu_lt, q[0].lt);
                chk("alu_ltu", alu_ltu, q[0].ltu);
                chk("out_rd", out_rd, q[0].rd);
            end
        end
    endtask

    task automatic set_instr(input logic [4:0] rs1, input logic [31:0] v1,
                             input logic [4:0] rs2, input logic [31:0] v2,
                             input logic [4:0] rd, input logic use_imm,
                             input logic [31:0] imm, input logic [2:0] f3,
                             input logic b30);
        in_valid   = 1'b1;
        in_rs1     = rs1;
        in_rs1_val = v1;
        in_rs2     = rs2;
        in_rs2_val = v2;
        in_rd      = rd;
        in_use_imm = use_imm;
        in_imm     = imm;
        in_funct3  = f3;
        in_b30     = b30;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        m_valid = 1'b0;
        rst = 1'b1;
        in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
        in_rs1_val = 0; in_rs2_val = 0; in_imm = 0; in_use_imm = 0;
        in_funct3 = 0; in_b30 = 0;
        fwd_mem_valid = 0; fwd_wb_valid = 0; fwd_mem_rd = 0; fwd_wb_rd = 0;
        fwd_mem_data = 0; fwd_wb_data = 0;
        flush = 0; out_ready = 1;

        // Reset for two cycles, then idle
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        chk("reset_in_ready", in_ready, 1);
        rst = 1'b0;
        step();

        // R-type sub
        set_instr(5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 1'b0, 32'd0, 3'b000, 1'b1);
        step();
        chk("sub_a", alu_a, 32'd5);
        chk("sub_b", alu_b, 32'd7);
        chk("sub_ctl", alu_control, 1);
        chk("sub_lt", alu_lt, 1);
        chk("sub_ltu", alu_ltu, 1);
        in_valid = 0;
        step();

        // addi then srai back to back
        set_instr(5'd1, 32'd3, 5'd2, 32'd9, 5'd4, 1'b1, 32'hFFFF_FFFF, 3'b000, 1'b1);
        step();
        chk("addi_ctl", alu_control, 0);
        chk("addi_b", alu_b, 32'hFFFF_FFFF);
        chk("addi_lt", alu_lt, 0);
        chk("addi_ltu", alu_ltu, 1);
        in_funct3 = 3'b101;
        step();
        chk("srai_ctl", alu_control, 1);

        // Forward priority
        set_instr(5'd4, 32'h11, 5'd6, 32'h22, 5'd7, 1'b0, 32'd0, 3'b111, 1'b0);
        fwd_mem_valid = 1; fwd_mem_rd = 5'd4; fwd_mem_data = 32'hAA;
        fwd_wb_valid = 1; fwd_wb_rd = 5'd4; fwd_wb_data = 32'hBB;
        step();
        chk("fwd_mem_a", alu_a, 32'hAA);
        fwd_mem_valid = 0;
        step();
        chk("fwd_wb_a", alu_a, 32'hBB);
        in_rs1 = 5'd0; in_rs1_val = 32'h55;
        fwd_mem_valid = 1; fwd_mem_rd = 5'd0;
        step();
        chk("fwd_x0_a", alu_a, 32'd0);
        fwd_mem_valid = 0;
        fwd_wb_rd = 5'd6; fwd_wb_data = 32'hCC;
        step();
        chk("fwd_wb_b", alu_b, 32'hCC);
        fwd_wb_valid = 0;

        // Stall with new data waiting
        set_instr(5'd8, 32'h100, 5'd9, 32'h200, 5'd10, 1'b0, 32'd0, 3'b010, 1'b0);
        step();
        set_instr(5'd11, 32'h300, 5'd12, 32'h50, 5'd13, 1'b0, 32'd0, 3'b011, 1'b1);
        out_ready = 0;
        repeat (3) begin
            step();
            chk("stall_a", alu_a, 32'h100);
        end
        out_ready = 1;
        step();
        chk("stall_release_a", alu_a, 32'h300);
        chk("stall_release_valid", out_valid, 1);

        // Flush with simultaneous capture, then a clean capture
        flush = 1;
        step();
        flush = 0;
        set_instr(5'd14, 32'h7, 5'd15, 32'h7, 5'd16, 1'b0, 32'd0, 3'b100, 1'b0);
        step();
        chk("post_flush_valid", out_valid, 1);

        // Reset while stalled drops the held instruction
        out_ready = 0;
        in_valid = 1;
        step();
        rst = 1;
        step();
        rst = 0;
        out_ready = 1;
        in_valid = 0;
        step();

        // Randomized traffic with stalls, flushes and forwarding
        for (int i = 0; i < 200; i++) begin
            set_instr(5'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 3)), $urandom,
                      5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom,
                      3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            in_valid      = 1'($urandom_range(0, 1));
            fwd_mem_valid = 1'($urandom_range(0, 1));
            fwd_mem_rd    = 5'($urandom_range(0, 3));
            fwd_mem_data  = $urandom;
            fwd_wb_valid  = 1'($urandom_range(0, 1));
            fwd_wb_rd     = 5'($urandom_range(0, 3));
            fwd_wb_data   = $urandom;
            flush         = ($urandom_range(0, 9) == 0);
            out_ready     = ($urandom_range(0, 3) != 0);
            step();
        end

        in_valid = 0;
        flush = 0;
        out_ready = 1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
